// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared state, cycle-type and constant definitions for the Z80 bus responder
package z80_bus_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [2:0] {
        CYC_NONE, CYC_MEMRD, CYC_MEMWR, CYC_IORD, CYC_IOWR, CYC_INTA, CYC_RFSH
    } cycle_t;
    localparam logic [7:0] BYTE_FF = 8'hFF;
endpackage

// File: rtl/z80_cycle_decode.sv
// z80_cycle_decode: classifies the sampled Z80 bus strobes into a cycle type
module z80_cycle_decode
    import z80_bus_pkg::*;
(
    input  logic   mreq_n,
    input  logic   iorq_n,
    input  logic   rd_n,
    input  logic   wr_n,
    input  logic   m1_n,
    input  logic   rfsh_n,
    output cycle_t cyc
);
    always_comb begin
        cyc = (!iorq_n && !m1_n)           ? CYC_INTA  :
              (!iorq_n && m1_n && !rd_n)   ? CYC_IORD  :
              (!iorq_n && m1_n && !wr_n)   ? CYC_IOWR  :
              (!mreq_n && !rd_n && rfsh_n) ? CYC_MEMRD :
              (!mreq_n && !wr_n)           ? CYC_MEMWR :
              (!mreq_n && !rfsh_n)         ? CYC_RFSH  : CYC_NONE;
    end
endmodule

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: answers tv80s bus cycles with wait states and a req/ack backend handshake
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int          TIMEOUT      = 64,
    parameter logic [7:0]  INTA_VECTOR  = 8'hFF,
    parameter int          IO_FULL_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_di,
    output logic        wait_n,
    output logic        be_req,
    output logic        be_we,
    output logic        be_io,
    output logic [15:0] be_addr,
    output logic [7:0]  be_wdata,
    input  logic [7:0]  be_rdata,
    input  logic        be_ack,
    output logic        err
);
    localparam logic [7:0] TO = 8'(TIMEOUT);

    cycle_t      cyc;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, di_q, di_d, wdata_q, wdata_d;
    logic [15:0] addr_q, addr_d;
    logic        req_q, req_d, we_q, we_d, io_q, io_d, err_q, err_d;
    logic        access, is_io, is_wr;

    z80_cycle_decode u_dec (
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n), .cyc(cyc)
    );

    assign is_io  = (cyc == CYC_IORD) || (cyc == CYC_IOWR);
    assign is_wr  = (cyc == CYC_MEMWR) || (cyc == CYC_IOWR);
    assign access = is_io || (cyc == CYC_MEMRD) || (cyc == CYC_MEMWR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        di_d    = di_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        req_d   = req_q;
        we_d    = we_q;
        io_d    = io_q;
        err_d   = err_q;
        if (state_q == IDLE && access) begin
            addr_d  = (is_io && IO_FULL_ADDR == 0) ? {8'h00, A[7:0]} : A;
            wdata_d = cpu_dout;
            we_d    = is_wr;
            io_d    = is_io;
            req_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = REQ;
        end else if (state_q == REQ) begin
            cnt_d = cnt_q + 8'd1;
            // an ack in the timeout cycle still completes the access normally
            if (be_ack) begin
                di_d    = we_q ? di_q : be_rdata;
                req_d   = 1'b0;
                state_d = DONE;
            end else if (cnt_q + 8'd1 == TO) begin
                di_d    = BYTE_FF;
                err_d   = 1'b1;
                req_d   = 1'b0;
                state_d = DONE;
            end
        end else if (state_q == DONE && mreq_n && iorq_n) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            di_q    <= BYTE_FF;
            wdata_q <= 8'd0;
            addr_q  <= 16'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            di_q    <= di_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            io_q    <= io_d;
            err_q   <= err_d;
        end
    end

    assign wait_n   = !(access && state_q != DONE);
    assign cpu_di   = (cyc == CYC_INTA) ? INTA_VECTOR : di_q;
    assign be_req   = req_q;
    assign be_we    = we_q;
    assign be_io    = io_q;
    assign be_addr  = addr_q;
    assign be_wdata = wdata_q;
    assign err      = err_q;
endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder: vector table plus directed timeout and reset sequences with a request scoreboard
module tb_z80_bus_responder;
    logic        clk = 1'b0, reset = 1'b1;
    logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1, rfsh_n = 1'b1;
    logic [15:0] A = 16'd0;
    logic [7:0]  cpu_dout = 8'd0, be_rdata = 8'd0;
    logic        be_ack = 1'b0;
    logic [7:0]  cpu_di, be_wdata, cpu_di2, be_wdata2;
    logic        wait_n, be_req, be_we, be_io, err;
    logic        wait_n2, be_req2, be_we2, be_io2, err2;
    logic [15:0] be_addr, be_addr2;
    int          tests = 0, fails = 0;
    logic        req_prev = 1'b0;

    localparam logic [7:0] IV = 8'hC7;

    typedef struct {
        logic we, io;
        logic [15:0] addr, addr_full;
        logic [7:0] wdata;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
        logic [15:0] a;
        logic [7:0] dout;
        int lat;
        logic [7:0] rdata;
        logic acc, we, io;
        logic [15:0] addr;
        logic [7:0] di;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    z80_bus_responder #(.TIMEOUT(4), .INTA_VECTOR(IV), .IO_FULL_ADDR(0)) dut (
        .clk(clk), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n), .A(A), .cpu_dout(cpu_dout), .cpu_di(cpu_di), .wait_n(wait_n),
        .be_req(be_req), .be_we(be_we), .be_io(be_io), .be_addr(be_addr), .be_wdata(be_wdata),
        .be_rdata(be_rdata), .be_ack(be_ack), .err(err)
    );

    z80_bus_responder #(.TIMEOUT(4), .INTA_VECTOR(IV), .IO_FULL_ADDR(1)) dut_full (
        .clk(clk), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n), .A(A), .cpu_dout(cpu_dout), .cpu_di(cpu_di2), .wait_n(wait_n2),
        .be_req(be_req2), .be_we(be_we2), .be_io(be_io2), .be_addr(be_addr2), .be_wdata(be_wdata2),
        .be_rdata(be_rdata), .be_ack(be_ack), .err(err2)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (be_req && !req_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_req: be_req rose with no access pending at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_we", be_we, e.we);
                chk("sb_io", be_io, e.io);
                chk("sb_addr", be_addr, e.addr);
                chk("sb_wdata", be_wdata, e.wdata);
                chk("sb_req_full", be_req2, 1'b1);
                chk("sb_we_full", be_we2, e.we);
                chk("sb_addr_full", be_addr2, e.addr_full);
            end
        end
        req_prev <= be_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        mreq_n = v.mreq_n; iorq_n = v.iorq_n; rd_n = v.rd_n; wr_n = v.wr_n;
        m1_n = v.m1_n; rfsh_n = v.rfsh_n; A = v.a; cpu_dout = v.dout;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v);
        #1;
        chk($sformatf("v%0d_wait_first", idx), wait_n, !v.acc);
        if (!v.iorq_n && !v.m1_n) chk($sformatf("v%0d_inta_di", idx), cpu_di, IV);
        if (v.acc) sb.push_back('{v.we, v.io, v.addr, v.a, v.dout});
        tick();
        if (v.acc) begin
            for (int i = 0; i < v.lat; i++) begin
                chk($sformatf("v%0d_req_c%0d", idx, i), be_req, 1'b1);
                chk($sformatf("v%0d_wait_c%0d", idx, i), wait_n, 1'b0);
                tick();
            end
            be_ack = 1'b1;
            be_rdata = v.rdata;
            chk($sformatf("v%0d_req_ack", idx), be_req, 1'b1);
            chk($sformatf("v%0d_wait_ack", idx), wait_n, 1'b0);
            tick();
            be_ack = 1'b0;
            chk($sformatf("v%0d_req_done", idx), be_req, 1'b0);
            chk($sformatf("v%0d_wait_done", idx), wait_n, 1'b1);
            chk($sformatf("v%0d_di_done", idx), cpu_di, v.di);
            tick();
            chk($sformatf("v%0d_no_retrigger", idx), be_req, 1'b0);
            chk($sformatf("v%0d_wait_hold", idx), wait_n, 1'b1);
        end else begin
            chk($sformatf("v%0d_no_req", idx), be_req, 1'b0);
            chk($sformatf("v%0d_wait_idle", idx), wait_n, 1'b1);
        end
        release_bus();
        tick();
        chk($sformatf("v%0d_di_after", idx), cpu_di, v.di);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //             mreq iorq rd wr m1 rf  A         dout  lat rdata  acc we io addr       di
        vecs[0] = '{0, 1, 0, 1, 1, 1, 16'hA169, 8'h01, 2, 8'h50, 1, 0, 0, 16'hA169, 8'h50};
        vecs[1] = '{0, 1, 1, 0, 1, 1, 16'h1234, 8'h3C, 0, 8'hAA, 1, 1, 0, 16'h1234, 8'h50};
        vecs[2] = '{1, 0, 1, 0, 1, 1, 16'h127F, 8'h5A, 1, 8'h00, 1, 1, 1, 16'h007F, 8'h50};
        vecs[3] = '{1, 0, 0, 1, 1, 1, 16'hAB42, 8'h02, 1, 8'h99, 1, 0, 1, 16'h0042, 8'h99};
        vecs[4] = '{0, 1, 1, 1, 1, 0, 16'h0013, 8'h03, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h99};
        vecs[5] = '{1, 0, 1, 1, 0, 1, 16'h0038, 8'h04, 0, 8'h00, 0, 0, 0, 16'h0000, 8'h99};
        vecs[6] = '{0, 1, 0, 1, 1, 1, 16'h0000, 8'h05, 0, 8'h00, 1, 0, 0, 16'h0000, 8'h00};
        vecs[7] = '{0, 1, 0, 1, 1, 1, 16'hFFFF, 8'h06, 3, 8'hA5, 1, 0, 0, 16'hFFFF, 8'hA5};
        vecs[8] = '{1, 1, 1, 1, 1, 1, 16'h5555, 8'h07, 0, 8'h00, 0, 0, 0, 16'h0000, 8'hA5};
        vecs[9] = '{0, 1, 0, 1, 0, 1, 16'h0100, 8'h08, 1, 8'h46, 1, 0, 0, 16'h0100, 8'h46};

        tick();
        tick();
        chk("rst_di", cpu_di, 8'hFF);
        chk("rst_wait", wait_n, 1'b1);
        chk("rst_req", be_req, 1'b0);
        chk("rst_we", be_we, 1'b0);
        chk("rst_io", be_io, 1'b0);
        chk("rst_addr", be_addr, 16'h0000);
        chk("rst_wdata", be_wdata, 8'h00);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
        chk("err_clear_after_table", err, 1'b0);

        // backend never answers: request must be abandoned after four cycles
        mreq_n = 1'b0; rd_n = 1'b0; A = 16'h2000; cpu_dout = 8'h11;
        sb.push_back('{1'b0, 1'b0, 16'h2000, 16'h2000, 8'h11});
        #1;
        chk("to_wait_first", wait_n, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req_c%0d", i), be_req, 1'b1);
            chk($sformatf("to_err_c%0d", i), err, 1'b0);
            tick();
        end
        chk("to_req_drop", be_req, 1'b0);
        chk("to_di", cpu_di, 8'hFF);
        chk("to_err", err, 1'b1);
        chk("to_wait", wait_n, 1'b1);
        be_ack = 1'b1;
        be_rdata = 8'h33;
        tick();
        be_ack = 1'b0;
        chk("to_late_ack_di", cpu_di, 8'hFF);
        release_bus();
        tick();
        run_vec(vecs[0], 90);
        chk("to_err_sticky", err, 1'b1);

        // reset during REQ, then a stray ack
        mreq_n = 1'b0; rd_n = 1'b0; A = 16'h3000; cpu_dout = 8'h22;
        sb.push_back('{1'b0, 1'b0, 16'h3000, 16'h3000, 8'h22});
        tick();
        chk("rr_req", be_req, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        chk("rr_req_drop", be_req, 1'b0);
        chk("rr_di", cpu_di, 8'hFF);
        chk("rr_err_cleared", err, 1'b0);
        release_bus();
        reset = 1'b0;
        be_ack = 1'b1;
        be_rdata = 8'h77;
        tick();
        be_ack = 1'b0;
        chk("rr_late_ack_di", cpu_di, 8'hFF);
        chk("rr_late_ack_req", be_req, 1'b0);
        tick();
        run_vec(vecs[6], 91);

        tick();
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Target-side (responder) bus interface for the tv80s core: decodes Z80 memory, I/O and interrupt-acknowledge cycles and answers them.
- Inserts wait states and forwards each access to a synchronous backing store over a req/ack handshake.
- Replaces ad-hoc negedge memory models so that SoC memories and peripherals with arbitrary latency can sit behind the CPU.

Parameters:
- TIMEOUT, 64, maximum cycles to wait for be_ack before aborting the access (1..255).
- INTA_VECTOR, 8'hFF, byte driven on cpu_di during interrupt-acknowledge cycles.
- IO_FULL_ADDR, 0, 1 = be_addr carries all 16 bits for I/O cycles; 0 = upper byte forced to 8'h00.

Ports:
- clk  in  1  system clock, same clock as tv80s.
- reset  in  1  synchronous, active-high reset.
- mreq_n  in  1  CPU memory request.
- iorq_n  in  1  CPU I/O request.
- rd_n  in  1  CPU read strobe.
- wr_n  in  1  CPU write strobe.
- m1_n  in  1  CPU opcode fetch / interrupt-acknowledge marker.
- rfsh_n  in  1  CPU refresh marker.
- A  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_di  out  8  read data to the CPU.
- wait_n  out  1  wait request to the CPU, active low.
- be_req  out  1  backend request, held high until be_ack or timeout.
- be_we  out  1  1 = write, 0 = read.
- be_io  out  1  1 = I/O space, 0 = memory space.
- be_addr  out  16  backend address.
- be_wdata  out  8  backend write data.
- be_rdata  in  8  backend read data, valid when be_ack = 1.
- be_ack  in  1  backend completion, one-cycle pulse.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset values (applied at the rising edge of clk while reset = 1):
  - cpu_di = 8'hFF, wait_n = 1, be_req = 0, be_we = 0, be_io = 0, be_addr = 0, be_wdata = 0, err = 0.
  - State = IDLE, timeout counter = 0.
- Cycle qualification, combinational on the sampled bus:
  - MEMRD: !mreq_n & !rd_n & rfsh_n.
  - MEMWR: !mreq_n & !wr_n.
  - IORD / IOWR: !iorq_n & m1_n & !rd_n / !wr_n.
  - INTA: !iorq_n & !m1_n.
  - Refresh (!mreq_n & !rfsh_n) is ignored: no request, no wait.
- States: IDLE, REQ, DONE.
- IDLE:
  - On a qualifying MEMRD/MEMWR/IORD/IOWR, latch A (I/O upper byte per IO_FULL_ADDR), cpu_dout, direction and space.
  - Assert be_req on the next edge and go to REQ. Counter = 0.
- REQ:
  - be_req = 1; the counter increments each cycle.
  - On be_ack: read data loads cpu_di; drop be_req; go to DONE.
  - If the counter reaches TIMEOUT without be_ack: drop be_req, cpu_di = 8'hFF, set err, go to DONE.
  - be_ack arriving in the same cycle as the timeout wins; err is not set.
- DONE: return to IDLE once mreq_n = 1 and iorq_n = 1 are sampled together. A back-to-back strobe therefore cannot retrigger the same access.
- wait_n is combinational:
  - Low when a qualifying strobe is active and the state is IDLE or REQ.
  - High in DONE, for INTA, and for refresh.
  - This guarantees the CPU sees wait_n low in T2 of the first access cycle.
- Minimum latency: 1 cycle from strobe to be_req. Wait states = backend ack latency + 1.
- INTA: cpu_di = INTA_VECTOR combinationally while INTA is qualified; no backend traffic; no state change.
- cpu_di holds its last read value between accesses. It is not cleared by writes.
- Reset mid-operation: be_req drops at that edge; any ack arriving later is ignored; the state returns to IDLE.
- be_ack outside REQ is ignored.

Decomposition:
- Shared package z80_bus_pkg holds:
  - enum state_t {IDLE, REQ, DONE};
  - typedef cycle_t {CYC_NONE, CYC_MEMRD, CYC_MEMWR, CYC_IORD, CYC_IOWR, CYC_INTA, CYC_RFSH};
  - localparam BYTE_FF = 8'hFF.
- One natural sub-module: z80_cycle_decode, purely combinational, mapping the bus strobes to cycle_t. All other logic stays in the top module.

Test Plan:
- MEMRD at A=16'hA169, backend acks 3 cycles after be_req with 8'h50:
  - be_req high exactly 3 cycles; wait_n low until the ack cycle; cpu_di = 8'h50.
  - tv80s executing LD B,(HL) (opcode 8'h46) with HL=16'hA169 ends with B = 8'h50.
- MEMWR of 8'h3C to 16'h1234 with 0-cycle ack:
  - be_we = 1, be_addr = 16'h1234, be_wdata = 8'h3C, a single be_req pulse; wait_n returns high the next cycle.
- IOWR to port 8'h7F with A = 16'h127F and IO_FULL_ADDR = 0:
  - be_io = 1, be_addr = 16'h007F.
  - Refresh cycles during the surrounding M1 produce no be_req.
- INTA with INTA_VECTOR = 8'hC7: cpu_di = 8'hC7, wait_n stays 1, be_req stays 0.
- MEMRD with backend never acking and TIMEOUT = 4:
  - be_req drops after 4 cycles; cpu_di = 8'hFF; err = 1 and stays set until reset.
- Reset asserted while in REQ, followed by a late be_ack:
  - be_req = 0 at the reset edge; cpu_di = 8'hFF; the late ack leaves cpu_di and the state unchanged.
